dice_roller: RTL and testbench

DICE_ROLLER -- requirements
Module: dice_roller

---
 rtl/dice_roller.sv | 157 +++++++++++++++
 tb/tb_dice_roller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_roller.sv
// Wishbone-mapped dice roller: a 32-bit Galois LFSR supplies the dividend and a
// bit-serial restoring divider reduces it to a 1..sides result.
module dice_roller (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [5:0]  status_o,
  output logic        roll_done_o
);

  localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [1:0] REG_SEED   = 2'd0;
  localparam logic [1:0] REG_ROLL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [8:0]  sides_q, sides_d;
  logic [8:0]  result_q, result_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [5:0]  status_q, status_d;
  logic        done_q, done_d;
  logic [31:0] dividend_q, dividend_d;
  logic [8:0]  rem_q, rem_d;
  logic [5:0]  iter_q, iter_d;

  logic        bus_req;
  logic [1:0]  reg_sel;
  logic [9:0]  trial;
  logic [9:0]  diff;
  logic [31:0] read_mux;

  // Byte selects and the undecoded address bits have no effect on this block.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

  assign bus_req = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign reg_sel = wbs_adr_i[3:2];
  assign trial   = {rem_q, dividend_q[31]};
  assign diff    = trial - {1'b0, sides_q};

  always_comb begin
    read_mux = 32'h0;
    case (reg_sel)
      REG_SEED:   read_mux = lfsr_q;
      REG_ROLL:   read_mux = {busy_q, valid_q, 21'h0, result_q};
      REG_STATUS: read_mux = {26'h0, status_q};
      REG_COUNT:  read_mux = {16'h0, count_q};
      default:    read_mux = 32'h0;
    endcase
  end

  always_comb begin
    ack_d      = bus_req;
    dat_d      = (bus_req && !wbs_we_i) ? read_mux : 32'h0;
    lfsr_d     = lfsr_q;
    sides_d    = sides_q;
    result_d   = result_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    count_d    = count_q;
    status_d   = status_q;
    done_d     = 1'b0;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    iter_d     = iter_q;

    // Iterations run on counts 0..31; count 32 is the completion cycle.
    if (busy_q) begin
      if (iter_q == 6'd32) begin
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        result_d = rem_q + 9'd1;
        done_d   = 1'b1;
        count_d  = count_q + 16'd1;
      end else begin
        rem_d      = diff[9] ? trial[8:0] : diff[8:0];
        dividend_d = {dividend_q[30:0], 1'b0};
        iter_d     = iter_q + 6'd1;
      end
    end

    if (bus_req && wbs_we_i) begin
      case (reg_sel)
        REG_SEED:   lfsr_d = (wbs_dat_i == 32'h0) ? LFSR_SEED : wbs_dat_i;
        REG_ROLL: begin
          if (!busy_q) begin
            sides_d    = (wbs_dat_i[7:0] == 8'h0) ? 9'd256 : {1'b0, wbs_dat_i[7:0]};
            dividend_d = lfsr_q;
            lfsr_d     = lfsr_step(lfsr_q);
            busy_d     = 1'b1;
            valid_d    = 1'b0;
            rem_d      = 9'd0;
            iter_d     = 6'd0;
          end
        end
        REG_STATUS: status_d = wbs_dat_i[5:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      lfsr_q     <= LFSR_SEED;
      sides_q    <= 9'd6;
      result_q   <= 9'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= 16'h0;
      status_q   <= 6'h0;
      done_q     <= 1'b0;
      dividend_q <= 32'h0;
      rem_q      <= 9'd0;
      iter_q     <= 6'd0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      lfsr_q     <= lfsr_d;
      sides_q    <= sides_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      status_q   <= status_d;
      done_q     <= done_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      iter_q     <= iter_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign status_o    = status_q;
  assign roll_done_o = done_q;

endmodule

// File: tb/tb_dice_roller.sv
// Directed bench for dice_roller: register access, roll latency and results,
// busy-write rejection, status pads, bulk rolls and mid-roll reset.
module tb_dice_roller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = 32'h0;
  logic [31:0] wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat;
  logic [5:0]  status;
  logic        roll_done;

  int n_checks = 0;
  int n_pass   = 0;
  bit verbose  = 1'b1;

  always #5 clk = ~clk;

  dice_roller dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (wdat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .status_o    (status),
    .roll_done_o (roll_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] v);
    lfsr_model = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  task automatic wb_xfer(input logic w, input logic [1:0] r, input logic [31:0] d,
                         output logic [31:0] q);
    int n;
    n = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = {28'h0, r, 2'b00}; wdat = d;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    q = rdat;
    chk("ack_latency", n, 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (verbose)
      $display("%s reg=%0d wdata=0x%08h rdata=0x%08h ack_cycles=%0d",
               w ? "WR" : "RD", r, d, q, n);
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, r, d, q);
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] q;
    wb_xfer(1'b0, r, 32'h0, q);
    chk(tag, q, exp);
  endtask

  // Returns the number of edges until roll_done_o is seen (0 on timeout).
  task automatic wait_done(output int n);
    int k;
    n = 0;
    for (k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      if (roll_done) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int bad_range;
    int pulses;
    logic [31:0] m;
    logic [31:0] q;
    logic [8:0]  exp_res;

    // Reset state on the pins
    #12;
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_status", {26'h0, status}, 32'h0);
    chk("rst_done", {31'h0, roll_done}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    rd_chk("rst_seed",   2'd0, 32'hACE1_ACE1);
    rd_chk("rst_roll",   2'd1, 32'h0);
    rd_chk("rst_status_rd", 2'd2, 32'h0);
    rd_chk("rst_count",  2'd3, 32'h0);

    // Seed 13, sides 6: 13 mod 6 + 1 = 2; LFSR steps 13 -> 0x80200005
    wr(2'd0, 32'd13);
    wr(2'd1, 32'd6);
    wait_done(n);
    chk("roll_latency", n, 33);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'h0, roll_done}, 32'h0);
    rd_chk("roll13_result", 2'd1, 32'h4000_0002);
    rd_chk("roll13_count",  2'd3, 32'd1);
    rd_chk("roll13_seed",   2'd0, 32'h8020_0005);

    // Seed rewritten mid-roll: LFSR follows the write, result does not change
    wr(2'd0, 32'd13);
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h0000_0077);
    wait_done(n);
    chk("seed_mid_done", {31'h0, (n != 0)}, 32'h1);
    rd_chk("seed_mid_result", 2'd1, 32'h4000_0002);
    rd_chk("seed_mid_seed",   2'd0, 32'h0000_0077);

    // sides = 1 always gives 1
    wr(2'd0, 32'h1234_5678);
    wr(2'd1, 32'd1);
    wait_done(n);
    chk("side1_done", {31'h0, (n != 0)}, 32'h1);
    rd_chk("side1_result", 2'd1, 32'h4000_0001);

    // sides = 0 means 256: 0xDEADBEEF mod 256 + 1 = 0xF0; busy write ignored
    wr(2'd0, 32'hDEAD_BEEF);
    wr(2'd1, 32'd0);
    wr(2'd1, 32'd5);
    rd_chk("busy_read", 2'd1, 32'h8000_0001);
    wait_done(n);
    chk("side256_done", {31'h0, (n != 0)}, 32'h1);
    rd_chk("side256_result", 2'd1, 32'h4000_00F0);
    rd_chk("side256_seed",   2'd0, 32'hEF76_DF74);
    rd_chk("count_after_busy_wr", 2'd3, 32'd4);

    // Status pads and read-only COUNT
    wr(2'd2, 32'h1F);
    chk("status_1f", {26'h0, status}, 32'h1F);
    wr(2'd2, 32'h1E);
    chk("status_1e", {26'h0, status}, 32'h1E);
    wr(2'd2, 32'hFFFF_FF20);
    chk("status_err", {26'h0, status}, 32'h20);
    rd_chk("status_rd", 2'd2, 32'h20);
    wr(2'd3, 32'hFFFF);
    rd_chk("count_ro", 2'd3, 32'd4);

    // 1000 rolls of a d6 from the default seed
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    wr(2'd0, 32'h0);
    rd_chk("seed_zero", 2'd0, 32'hACE1_ACE1);
    verbose = 1'b0;
    m = 32'hACE1_ACE1;
    bad_range = 0;
    for (int i = 0; i < 1000; i++) begin
      wr(2'd1, 32'd6);
      wait_done(n);
      chk("bulk_done", {31'h0, (n != 0)}, 32'h1);
      wb_xfer(1'b0, 2'd1, 32'h0, q);
      exp_res = 9'(m % 32'd6) + 9'd1;
      chk("bulk_result", q, {2'b01, 21'h0, exp_res});
      if (q[8:0] < 9'd1 || q[8:0] > 9'd6) bad_range++;
      m = lfsr_model(m);
    end
    verbose = 1'b1;
    $display("bulk: 1000 rolls, out-of-range=%0d", bad_range);
    chk("bulk_range", bad_range, 0);
    rd_chk("bulk_count", 2'd3, 32'd1000);
    rd_chk("bulk_seed",  2'd0, m);

    // Reset 10 cycles into a roll
    wr(2'd2, 32'h2A);
    wr(2'd1, 32'd6);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_status", {26'h0, status}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (roll_done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    rd_chk("midrst_roll",  2'd1, 32'h0);
    rd_chk("midrst_count", 2'd3, 32'h0);
    rd_chk("midrst_seed",  2'd0, 32'hACE1_ACE1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
